multi_mode_counter: RTL

Parametrised successor to the fixed 4-bit even counter. One counter core that counts up or down in binary, even-only or odd-only sequences. It has a programmable upper limit, wrap or saturate behaviour, synchronous load, count enable and a terminal-count pulse. It is the common counter block used across the counter suite, and mode, limit and load are driven by the surrounding control logic.

---
 rtl/multi_mode_counter_if.sv | 24 ++
 rtl/multi_mode_counter.sv | 96 +++++++++
 2 files changed

// File: rtl/multi_mode_counter_if.sv
// Control and status bundle for multi_mode_counter.
// master drives the controls; slave is the counter.
interface multi_mode_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] limit;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Cout;
  logic             tc;

  modport master (
    output en, mode, limit, sat, load, load_val,
    input  Cout, tc
  );

  modport slave (
    input  en, mode, limit, sat, load, load_val,
    output Cout, tc
  );
endinterface

// File: rtl/multi_mode_counter.sv
// Up/down counter: binary, even or odd sequences, limit,
// wrap/saturate, load and terminal-count pulse.
module multi_mode_counter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  multi_mode_counter_if.slave  bus
);
  logic [WIDTH-1:0] cnt, cnt_n;
  logic             tc_q, tc_n;
  logic             up, dn, par_even, par_odd, bad;
  logic [WIDTH:0]   cnt_x, lim_x, hi, lo, step, nxt;

  always_comb begin
    up       = 1'b0;
    dn       = 1'b0;
    par_even = 1'b0;
    par_odd  = 1'b0;
    case (bus.mode)
      3'b000: up = 1'b1;
      3'b001: dn = 1'b1;
      3'b010: begin up = 1'b1; par_even = 1'b1; end
      3'b011: begin up = 1'b1; par_odd  = 1'b1; end
      3'b100: begin dn = 1'b1; par_even = 1'b1; end
      3'b101: begin dn = 1'b1; par_odd  = 1'b1; end
      default: ;
    endcase
  end

  // Bounds and step carried in WIDTH+1 bits so full scale never aliases
  always_comb begin
    lim_x = {1'b0, bus.limit};
    cnt_x = {1'b0, cnt};
    hi    = lim_x;
    lo    = '0;
    step  = {{WIDTH{1'b0}}, 1'b1};
    if (par_even) begin
      hi   = {lim_x[WIDTH:1], 1'b0};
      step = {{(WIDTH-1){1'b0}}, 2'b10};
    end
    if (par_odd) begin
      lo   = {{WIDTH{1'b0}}, 1'b1};
      step = {{(WIDTH-1){1'b0}}, 2'b10};
      if (bus.limit[0])
        hi = lim_x;
      else if (bus.limit == '0)
        hi = {{WIDTH{1'b0}}, 1'b1};
      else
        hi = lim_x - {{WIDTH{1'b0}}, 1'b1};
    end
    bad = (par_even && cnt[0]) || (par_odd && !cnt[0])
       || (cnt_x > hi) || (cnt_x < lo);
  end

  always_comb begin
    cnt_n = cnt;
    tc_n  = 1'b0;
    nxt   = cnt_x;
    if (bus.load) begin
      cnt_n = bus.load_val;
    end else if (bus.en && (up || dn)) begin
      if (bad) begin
        nxt = up ? lo : hi;
      end else if (up) begin
        if (cnt_x < hi) begin
          nxt = cnt_x + step;
        end else begin
          tc_n = 1'b1;
          if (!bus.sat) nxt = lo;
        end
      end else begin
        if (cnt_x > lo) begin
          nxt = cnt_x - step;
        end else begin
          tc_n = 1'b1;
          if (!bus.sat) nxt = hi;
        end
      end
      cnt_n = nxt[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt  <= '0;
      tc_q <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      tc_q <= tc_n;
    end
  end

  assign bus.Cout = cnt;
  assign bus.tc   = tc_q;
endmodule
